sd_rrdemux: RTL and testbench
=============================

Name: sd_rrdemux

Overview:
- Single srdy/drdy consumer interface fanned out to `outputs` srdy/drdy producer interfaces; the distribution counterpart of the priority round-robin mux.
- Each transfer is either directed (explicit destination) or "any" (round-robin among ready, enabled outputs).
- Every output has a one-entry registered holding stage, so p_srdy/p_data are flop outputs.
- Sits in front of replicated engines/queues to spread or steer work items.

Parameters:
- width, 8, data bits per transfer
- outputs, 4, number of producer interfaces (2..16)
- dest_width, 3, destination field width; must satisfy outputs < 2**dest_width so that the all-ones code is free for "any"
- cnt_width, 8, width of saturating drop counter

Ports:
- clk  in  1  clock, posedge
- reset_n  in  1  synchronous, active-low reset
- c_data  in  width  input data
- c_dest  in  dest_width  destination; values 0..outputs-1 are directed; all-ones is "any"
- c_srdy  in  1  input valid
- c_drdy  out  1  input accepted this cycle (combinational)
- c_sel  out  outputs  one-hot output chosen for the current input; 0 when stalled or dropping
- p_data  out  width*outputs  output data, slice i = output i, registered
- p_srdy  out  outputs  output valid, registered
- p_drdy  in  outputs  output ready
- mask  in  outputs  output enable; 0 = output excluded from selection
- drop_err  out  1  registered one-cycle pulse after an illegal destination is dropped
- drop_cnt  out  cnt_width  saturating count of dropped transfers

Behaviour:
- Reset (reset_n=0 at posedge): p_srdy=0, p_data=0, drop_err=0, drop_cnt=0, rr pointer last=outputs-1, so the first "any" pick is output 0.
- Reset takes effect regardless of in-flight data; held entries are discarded.
- Per-output can_accept[i] = mask[i] & (!p_srdy[i] | p_drdy[i]). The combinational p_drdy→c_drdy path is intentional: a held entry draining and a new load into the same output may happen in the same cycle.
- Directed (c_dest < outputs):
  - sel = onehot(c_dest) if can_accept[c_dest], else 0.
  - A masked target stalls the input; it is never dropped.
- Any (c_dest all-ones):
  - sel = first i with can_accept[i], scanning last+1, last+2, … with wrap modulo outputs.
  - sel = 0 if no output can accept.
- Illegal (outputs ≤ c_dest < all-ones):
  - c_drdy=1, sel=0.
  - Data is discarded; drop_err=1 next cycle; drop_cnt increments and saturates at all-ones.
- c_drdy = c_srdy & (|sel | illegal). c_sel = sel gated by c_srdy.
- On each posedge, for each i:
  - if sel[i] & c_srdy: p_data[i] ← c_data, p_srdy[i] ← 1;
  - else if p_drdy[i]: p_srdy[i] ← 0;
  - otherwise hold.
  - p_data is unchanged when not loaded.
- Latency: accepted at edge t → p_srdy at t+1. Throughput is 1 transfer/cycle into a continuously draining output.
- RR pointer: last ← index(sel) only on an accepted "any" transfer. Directed transfers and drops leave the pointer unchanged.
- Simultaneous events:
  - Load and drain of the same output in one cycle → p_srdy stays 1 with new data.
  - mask deassertion does not flush a held entry; it still drains normally.
- p_data/p_srdy never change while p_srdy[i]=1 & p_drdy[i]=0 (hold rule).

Test Plan:
- Reset: outputs=4, all p_drdy=1, mask=4'hF; stream 8 "any" items D0..D7 → p_srdy pulses in order on outputs 0,1,2,3,0,1,2,3, each one cycle after acceptance; drop_cnt=0.
- Backpressure: p_drdy=4'b1101, "any" stream → outputs 0,2,3 rotate; output 1 holds its first item, p_data[1] stable until p_drdy[1] rises; c_drdy never 0 while another output is free.
- Directed stall: c_dest=2, mask[2]=0 → c_drdy=0, c_sel=0 for 5 cycles; raise mask[2] → accepted next cycle, p_srdy[2]=1 the following cycle.
- Illegal dest: dest_width=3, outputs=4, c_dest=5 for 3 transfers → c_drdy=1, no p_srdy, drop_err high 3 cycles, drop_cnt=3. With cnt_width=2, a 5th drop leaves drop_cnt=3.
- Same-cycle drain/load: output 0 full, p_drdy[0]=1, directed c_dest=0 → accepted; p_srdy[0] stays 1 with new data; the old item is observed transferred.
- Mid-stream reset: reset_n=0 with 3 outputs holding data → next cycle all p_srdy=0, drop_cnt=0; the next "any" item goes to output 0.

Source files
------------

// File: rtl/sd_rrdemux.sv
// sd_rrdemux: one srdy/drdy consumer port fanned out to `outputs` producer
// ports. Each transfer is either directed (c_dest < outputs) or "any"
// (c_dest all-ones, round-robin among ready, enabled outputs). Codes in
// between are illegal; they are accepted, discarded and counted.

// One-entry holding stage per output; p_srdy/p_data come straight from flops.
module sd_rrdemux_hold #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [width-1:0] data_i,
    input  logic             drdy_i,
    output logic             srdy_o,
    output logic [width-1:0] data_o
);
    logic             srdy_q;
    logic [width-1:0] data_q;

    // Load wins over drain, so a same-cycle drain+load keeps srdy high with new data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            srdy_q <= 1'b0;
            data_q <= '0;
        end else if (load_i) begin
            srdy_q <= 1'b1;
            data_q <= data_i;
        end else if (drdy_i) begin
            srdy_q <= 1'b0;
        end
    end

    assign srdy_o = srdy_q;
    assign data_o = data_q;
endmodule

module sd_rrdemux #(
    parameter int width      = 8,
    parameter int outputs    = 4,
    parameter int dest_width = 3,
    parameter int cnt_width  = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [width-1:0]          c_data,
    input  logic [dest_width-1:0]     c_dest,
    input  logic                      c_srdy,
    output logic                      c_drdy,
    output logic [outputs-1:0]        c_sel,
    output logic [width*outputs-1:0]  p_data,
    output logic [outputs-1:0]        p_srdy,
    input  logic [outputs-1:0]        p_drdy,
    input  logic [outputs-1:0]        mask,
    output logic                      drop_err,
    output logic [cnt_width-1:0]      drop_cnt
);
    localparam int PW = (outputs > 1) ? $clog2(outputs) : 1;
    localparam logic [dest_width-1:0] ANY = '1;

    logic [PW-1:0]        last_q, last_d, any_idx;
    logic [outputs-1:0]   can_accept, sel_any, sel_dir, sel;
    logic                 is_any, directed, illegal, found;
    logic                 drop_err_q, drop_err_d;
    logic [cnt_width-1:0] drop_cnt_q, drop_cnt_d;

    // An output can take a new item if enabled and either empty or draining now.
    assign can_accept = mask & (~p_srdy | p_drdy);

    assign is_any   = (c_dest == ANY);
    assign directed = (c_dest < dest_width'(outputs));
    assign illegal  = !is_any && !directed;

    // Round-robin scan starting just after the last "any" winner.
    always_comb begin : rr_scan
        int idx;
        sel_any = '0;
        any_idx = last_q;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= outputs; k++) begin
            idx = (int'(last_q) + k) % outputs;
            if (!found && can_accept[idx]) begin
                found        = 1'b1;
                sel_any[idx] = 1'b1;
                any_idx      = PW'(idx);
            end
        end
    end

    // Directed select: only the named output, and only when it can accept.
    always_comb begin
        sel_dir = '0;
        for (int i = 0; i < outputs; i++)
            sel_dir[i] = directed && (c_dest == dest_width'(i)) && can_accept[i];
    end

    assign sel    = is_any ? sel_any : sel_dir;
    assign c_sel  = c_srdy ? sel : '0;
    assign c_drdy = c_srdy && ((|sel) || illegal);

    // Next-state for pointer and drop bookkeeping; directed/dropped items leave the pointer alone.
    always_comb begin
        last_d     = last_q;
        drop_err_d = c_srdy && illegal;
        drop_cnt_d = drop_cnt_q;
        if (c_srdy && is_any && found)
            last_d = any_idx;
        if (c_srdy && illegal && (drop_cnt_q != '1))
            drop_cnt_d = drop_cnt_q + 1'b1;
    end

    // Pointer resets to the top index so the first "any" pick is output 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q     <= PW'(outputs - 1);
            drop_err_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            last_q     <= last_d;
            drop_err_q <= drop_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_err = drop_err_q;
    assign drop_cnt = drop_cnt_q;

    for (genvar g = 0; g < outputs; g++) begin : g_out
        sd_rrdemux_hold #(.width(width)) u_hold (
            .clk     (clk),
            .reset_n (reset_n),
            .load_i  (sel[g] && c_srdy),
            .data_i  (c_data),
            .drdy_i  (p_drdy[g]),
            .srdy_o  (p_srdy[g]),
            .data_o  (p_data[g*width +: width])
        );
    end
endmodule

// File: tb/tb_sd_rrdemux.sv
// Bench for sd_rrdemux: table-driven vectors for the input-side handshake and
// select, a per-output scoreboard checked whenever an output transfers.
module tb_sd_rrdemux;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  c_data;
    logic [2:0]  c_dest;
    logic        c_srdy;
    logic        c_drdy;
    logic [3:0]  c_sel;
    logic [31:0] p_data;
    logic [3:0]  p_srdy;
    logic [3:0]  p_drdy;
    logic [3:0]  mask;
    logic        drop_err;
    logic [1:0]  drop_cnt;

    int errors = 0;
    int checks = 0;

    logic [7:0] exq [4][$];

    typedef struct {
        logic       srdy;
        logic [2:0] dest;
        logic [7:0] data;
        logic [3:0] mask;
        logic [3:0] pdrdy;
        logic       exp_drdy;
        logic [3:0] exp_sel;
    } vec_t;

    sd_rrdemux #(.width(8), .outputs(4), .dest_width(3), .cnt_width(2)) dut (
        .clk(clk), .reset_n(reset_n), .c_data(c_data), .c_dest(c_dest),
        .c_srdy(c_srdy), .c_drdy(c_drdy), .c_sel(c_sel), .p_data(p_data),
        .p_srdy(p_srdy), .p_drdy(p_drdy), .mask(mask),
        .drop_err(drop_err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    function automatic vec_t mk(logic s, logic [2:0] d, logic [7:0] dat, logic [3:0] m,
                                logic [3:0] pd, logic ed, logic [3:0] es);
        vec_t v;
        v.srdy = s; v.dest = d; v.data = dat; v.mask = m; v.pdrdy = pd;
        v.exp_drdy = ed; v.exp_sel = es;
        return v;
    endfunction

    // Scoreboard: every output handshake must deliver the oldest expected item.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            for (int i = 0; i < 4; i++) begin
                if (p_srdy[i] && p_drdy[i]) begin
                    if (exq[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out%0d: got data %0h, expected no transfer", i, p_data[i*8 +: 8]);
                    end else begin
                        chk($sformatf("out%0d_data", i), 32'(p_data[i*8 +: 8]), 32'(exq[i].pop_front()));
                    end
                end
            end
        end
    end

    // Drive one vector at posedge+1, check the handshake at negedge, check load latency after the edge.
    task automatic apply(input vec_t v, input string nm);
        c_srdy = v.srdy; c_dest = v.dest; c_data = v.data; mask = v.mask; p_drdy = v.pdrdy;
        @(negedge clk);
        chk({nm, "_drdy"}, 32'(c_drdy), 32'(v.exp_drdy));
        chk({nm, "_sel"}, 32'(c_sel), 32'(v.exp_sel));
        for (int i = 0; i < 4; i++)
            if (v.exp_sel[i]) exq[i].push_back(v.data);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            if (v.exp_sel[i]) begin
                chk({nm, "_lat_srdy"}, 32'(p_srdy[i]), 32'd1);
                chk({nm, "_lat_data"}, 32'(p_data[i*8 +: 8]), 32'(v.data));
            end
        end
    endtask

    task automatic idle(input logic [3:0] m, input logic [3:0] pd);
        apply(mk(1'b0, 3'd0, 8'h00, m, pd, 1'b0, 4'b0000), "idle");
    endtask

    vec_t tbl[$];

    initial begin
        reset_n = 1'b0; c_srdy = 1'b0; c_dest = '0; c_data = '0;
        mask = 4'hF; p_drdy = 4'hF;

        // Stimulus tables: rr from reset, then rr with output 1 back-pressured.
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(1'b1, 3'd7, 8'h10 + 8'(k), 4'hF, 4'hF, 1'b1, 4'b0001 << (k % 4)));
        tbl.push_back(mk(1'b0, 3'd7, 8'h00, 4'hF, 4'hF, 1'b0, 4'b0000));
        tbl.push_back(mk(1'b1, 3'd7, 8'hB0, 4'hF, 4'b1101, 1'b1, 4'b0001));
        tbl.push_back(mk(1'b1, 3'd7, 8'hB1, 4'hF, 4'b1101, 1'b1, 4'b0010));
        tbl.push_back(mk(1'b1, 3'd7, 8'hB2, 4'hF, 4'b1101, 1'b1, 4'b0100));
        tbl.push_back(mk(1'b1, 3'd7, 8'hB3, 4'hF, 4'b1101, 1'b1, 4'b1000));
        tbl.push_back(mk(1'b1, 3'd7, 8'hB4, 4'hF, 4'b1101, 1'b1, 4'b0001));
        tbl.push_back(mk(1'b1, 3'd7, 8'hB5, 4'hF, 4'b1101, 1'b1, 4'b0100));
        tbl.push_back(mk(1'b1, 3'd7, 8'hB6, 4'hF, 4'b1101, 1'b1, 4'b1000));
        tbl.push_back(mk(1'b1, 3'd7, 8'hB7, 4'hF, 4'b1101, 1'b1, 4'b0001));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_p_srdy", 32'(p_srdy), 32'd0);
        chk("rst_p_data", p_data, 32'd0);
        chk("rst_drop_err", 32'(drop_err), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        reset_n = 1'b1;

        for (int n = 0; n < tbl.size(); n++)
            apply(tbl[n], $sformatf("tbl%0d", n));
        chk("rr_drop_cnt", 32'(drop_cnt), 32'd0);

        // Output 1 keeps its first item while others rotate.
        for (int n = 0; n < 3; n++) begin
            idle(4'hF, 4'b1101);
            chk("hold_srdy1", 32'(p_srdy[1]), 32'd1);
            chk("hold_data1", 32'(p_data[15:8]), 32'hB1);
        end
        idle(4'hF, 4'hF);
        idle(4'hF, 4'hF);

        // Directed to a masked output stalls, then goes once enabled.
        for (int n = 0; n < 5; n++)
            apply(mk(1'b1, 3'd2, 8'hC0, 4'b1011, 4'hF, 1'b0, 4'b0000), "dir_stall");
        apply(mk(1'b1, 3'd2, 8'hC0, 4'hF, 4'hF, 1'b1, 4'b0100), "dir_go");
        idle(4'hF, 4'hF);

        // Illegal destinations are swallowed and counted, saturating at 3.
        for (int k = 1; k <= 5; k++) begin
            logic [2:0] d;
            d = (k == 4) ? 3'd4 : ((k == 5) ? 3'd6 : 3'd5);
            apply(mk(1'b1, d, 8'hA0 + 8'(k), 4'hF, 4'hF, 1'b1, 4'b0000), "illegal");
            chk("drop_err_hi", 32'(drop_err), 32'd1);
            chk("drop_cnt", 32'(drop_cnt), (k < 3) ? 32'(k) : 32'd3);
            chk("drop_no_srdy", 32'(p_srdy), 32'd0);
        end
        idle(4'hF, 4'hF);
        chk("drop_err_lo", 32'(drop_err), 32'd0);
        chk("drop_cnt_sat", 32'(drop_cnt), 32'd3);

        // Same-cycle drain and load on output 0.
        apply(mk(1'b1, 3'd0, 8'hE0, 4'hF, 4'b1110, 1'b1, 4'b0001), "fill0");
        apply(mk(1'b1, 3'd0, 8'hE9, 4'hF, 4'b1110, 1'b0, 4'b0000), "full0_stall");
        apply(mk(1'b1, 3'd0, 8'hE1, 4'hF, 4'hF, 1'b1, 4'b0001), "drain_load0");
        idle(4'hF, 4'hF);

        // Masking an output does not flush its held entry; all-masked "any" stalls.
        apply(mk(1'b1, 3'd3, 8'hF0, 4'hF, 4'b0111, 1'b1, 4'b1000), "fill3");
        idle(4'b0111, 4'b0111);
        chk("masked_hold3", 32'(p_srdy[3]), 32'd1);
        apply(mk(1'b1, 3'd7, 8'hF5, 4'b0000, 4'hF, 1'b0, 4'b0000), "all_masked");
        idle(4'hF, 4'hF);

        // Mid-stream reset with three outputs holding data.
        apply(mk(1'b1, 3'd7, 8'h61, 4'hF, 4'h0, 1'b1, 4'b0010), "pre_rst_any1");
        apply(mk(1'b1, 3'd7, 8'h62, 4'hF, 4'h0, 1'b1, 4'b0100), "pre_rst_any2");
        apply(mk(1'b1, 3'd3, 8'h63, 4'hF, 4'h0, 1'b1, 4'b1000), "pre_rst_dir3");
        c_srdy = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) exq[i].delete();
        reset_n = 1'b1;
        chk("mrst_p_srdy", 32'(p_srdy), 32'd0);
        chk("mrst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("mrst_drop_err", 32'(drop_err), 32'd0);
        apply(mk(1'b1, 3'd7, 8'h70, 4'hF, 4'hF, 1'b1, 4'b0001), "post_rst_any");
        idle(4'hF, 4'hF);
        idle(4'hF, 4'hF);

        for (int i = 0; i < 4; i++)
            chk($sformatf("sb_empty%0d", i), 32'(exq[i].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
